// File: rtl/edge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : edge_pkg                                                          |
// | Desc   : Shared constants, FSM state codes and window-offset helper        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package edge_pkg;

    localparam int c_PIX_W_DEFAULT = 8;

    typedef logic [0:0] state_t;
    localparam state_t c_FILL = 1'b0;
    localparam state_t c_RUN  = 1'b1;

    // Bit offset of window element (r,c); r0 is the top row, c0 the left column.
    function automatic int win_idx(input int r, input int c, input int pix_w);
        return pix_w * (3 * r + c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : line_buffer                                                       |
// | Desc   : Single-port read-before-write row store, one entry per column     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module line_buffer
    import edge_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = c_PIX_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Asynchronous read returns the old contents in the same cycle as a write.
    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_window_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : line_window_3x3                                                   |
// | Desc   : Raster-stream 3x3 neighbourhood generator with two line buffers.  |
// |          Define LINE_WINDOW_BORDER_EN to emit border windows + win_border. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module line_window_3x3
    import edge_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = c_PIX_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win,
    output logic               win_valid,
    input  logic               win_ready,
    output logic               frame_done
`ifdef LINE_WINDOW_BORDER_EN
    ,
    output logic               win_border
`endif
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [9*PIX_W-1:0] r_win;
    logic [9*PIX_W-1:0] w_win_shift;
    logic               r_win_valid;
    logic               r_frame_done;
    logic [PIX_W-1:0]   w_lb0_q;
    logic [PIX_W-1:0]   w_lb1_q;
    logic               w_accept;
    logic               w_col_wrap;
    logic               w_row_wrap;
    logic               w_interior;
    logic               w_emit;

    assign pix_ready  = !r_win_valid || win_ready;
    assign w_accept   = pix_valid && pix_ready;
    assign w_col_wrap = (r_col == c_COL_LAST);
    assign w_row_wrap = (r_row == c_ROW_LAST);
    // RUN covers rows 2..H-1 except the very first pixel of row 2, still in FILL.
    assign w_interior = ((r_state == c_RUN) || (r_row == c_ROW_TWO)) && (r_col >= c_COL_TWO);

`ifdef LINE_WINDOW_BORDER_EN
    logic r_border;
    assign w_emit     = 1'b1;
    assign win_border = r_border;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_border <= 1'b0;
        end else if (w_accept) begin
            r_border <= !w_interior;
        end
    end
`else
    assign w_emit = w_interior;
`endif

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (pix_in),
        .o_rdata (w_lb0_q)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb0_q),
        .o_rdata (w_lb1_q)
    );

    // Columns slide left; the new right column is {two rows back, previous row, pixel}.
    always_comb begin
        w_win_shift = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_shift[win_idx(r, 0, PIX_W) +: PIX_W] = r_win[win_idx(r, 1, PIX_W) +: PIX_W];
            w_win_shift[win_idx(r, 1, PIX_W) +: PIX_W] = r_win[win_idx(r, 2, PIX_W) +: PIX_W];
        end
        w_win_shift[win_idx(0, 2, PIX_W) +: PIX_W] = w_lb1_q;
        w_win_shift[win_idx(1, 2, PIX_W) +: PIX_W] = w_lb0_q;
        w_win_shift[win_idx(2, 2, PIX_W) +: PIX_W] = pix_in;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FILL:  if (w_accept && (r_row == c_ROW_TWO)) w_state_nxt = c_RUN;
            c_RUN:   if (w_accept && w_col_wrap && w_row_wrap) w_state_nxt = c_FILL;
            default: w_state_nxt = c_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_win        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_accept && w_col_wrap && w_row_wrap;
            if (w_accept) begin
                r_win       <= w_win_shift;
                r_win_valid <= w_emit;
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_row_wrap ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign win        = r_win;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_line_window_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_line_window_3x3                                                |
// | Desc   : Randomised bench for line_window_3x3 on an 8x6 image              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_line_window_3x3;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PW = 8;
`ifdef LINE_WINDOW_BORDER_EN
    localparam int EXP_WIN = W * H;
`else
    localparam int EXP_WIN = (W - 2) * (H - 2);
`endif
    localparam logic [9*PW-1:0] FIRST_WIN = 72'h222120121110020100;
    localparam logic [9*PW-1:0] LAST_WIN  = 72'h575655474645373635;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [PW-1:0]   pix_in = '0;
    logic            pix_valid = 1'b0;
    logic            pix_ready;
    logic [9*PW-1:0] win;
    logic            win_valid;
    logic            win_ready = 1'b1;
    logic            frame_done;
`ifdef LINE_WINDOW_BORDER_EN
    logic            win_border;
`endif

    line_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win        (win),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
`ifdef LINE_WINDOW_BORDER_EN
        ,
        .win_border (win_border)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9*PW-1:0] w;
        logic            b;
    } exp_t;

    exp_t            q[$];
    logic [PW-1:0]   img [H][W];
    int              mcol, mrow;
    int              n_checks = 0, n_fail = 0;
    bit              armed = 0, exp_valid = 0, exp_fd = 0;
    bit              acc, cons, emit;
    exp_t            e;
    int              cons_cnt, bord_cnt, fd_cnt, stall_seen, acc_cnt, first_push_acc;
    bit              got_first;
    logic [9*PW-1:0] first_win, last_win;
    int              rdy_mode = 0, stall_left = 0;

    task automatic chk(input string name, input logic [9*PW-1:0] act, input logic [9*PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: windows are cut straight out of the stored image, indexed by raster position.
    always @(negedge clk) begin
        if (armed) begin
            chk("pix_ready", pix_ready, !exp_valid || win_ready);
            chk("win_valid", win_valid, exp_valid);
            chk("frame_done", frame_done, exp_fd);
            if (exp_valid && q.size() > 0) begin
                if (!q[0].b) chk("win", win, q[0].w);
`ifdef LINE_WINDOW_BORDER_EN
                chk("win_border", win_border, q[0].b);
`endif
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (win_valid && !win_ready) stall_seen++;
        end
        if (reset) begin
            armed = 1; q.delete(); exp_valid = 0; exp_fd = 0;
            mcol = 0; mrow = 0; acc_cnt = 0;
        end else if (armed) begin
            acc  = pix_valid && (!exp_valid || win_ready);
            cons = exp_valid && win_ready;
            if (cons && q.size() > 0) begin
                cons_cnt++;
                if (q[0].b) bord_cnt++;
                else begin
                    if (!got_first) begin first_win = q[0].w; got_first = 1; end
                    last_win = q[0].w;
                end
                void'(q.pop_front());
            end
            exp_fd = 0;
            if (acc) begin
                img[mrow][mcol] = pix_in;
                acc_cnt++;
                e.b = (mrow < 2) || (mcol < 2);
                e.w = '0;
                if (!e.b) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.w[PW*(3*i+j) +: PW] = img[mrow-2+i][mcol-2+j];
                    if (first_push_acc == 0) first_push_acc = acc_cnt;
                end
`ifdef LINE_WINDOW_BORDER_EN
                emit = 1;
`else
                emit = !e.b;
`endif
                if (emit) q.push_back(e);
                exp_valid = emit;
                exp_fd = (mrow == H-1) && (mcol == W-1);
                if (mcol == W-1) begin
                    mcol = 0;
                    mrow = (mrow == H-1) ? 0 : mrow + 1;
                end else begin
                    mcol++;
                end
            end else if (cons) begin
                exp_valid = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) win_ready = 1'b1;
            else if (rdy_mode == 1) win_ready = 1'($urandom_range(1));
            else if (stall_left > 0 && win_valid) begin win_ready = 1'b0; stall_left--; end
            else win_ready = 1'b1;
        end
    end

    task automatic clear_stats();
        cons_cnt = 0; bord_cnt = 0; fd_cnt = 0; stall_seen = 0;
        acc_cnt = 0; first_push_acc = 0; got_first = 0;
        first_win = '0; last_win = '0;
    endtask

    task automatic send_pix(input logic [PW-1:0] v, input int gap);
        int budget;
        while (gap > 0 && $urandom_range(99) < gap) begin
            pix_valid = 1'b0; @(posedge clk); #1;
        end
        pix_in = v; pix_valid = 1'b1; budget = 0;
        while (1) begin
            @(negedge clk);
            if (pix_ready) begin @(posedge clk); #1; pix_valid = 1'b0; break; end
            @(posedge clk); #1;
            if (++budget > 200) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: got pix_ready=0 expected accept within 200 cycles");
                pix_valid = 1'b0; break;
            end
        end
    endtask

    task automatic drain();
        int budget = 0;
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        while ((q.size() != 0 || win_valid) && budget < 100) begin @(posedge clk); budget++; end
        if (budget >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d queued expected 0", q.size());
        end
        #1;
    endtask

    task automatic run_frame(input bit rnd, input int gap);
        clear_stats();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pix(rnd ? PW'($urandom) : PW'(16*r + c), gap);
        drain();
        chk("win_count", 72'(cons_cnt), 72'(EXP_WIN));
        chk("frame_done_count", 72'(fd_cnt), 72'd1);
`ifdef LINE_WINDOW_BORDER_EN
        chk("border_count", 72'(bord_cnt), 72'd24);
`endif
        if (!rnd) begin
            chk("first_win", first_win, FIRST_WIN);
            chk("last_win", last_win, LAST_WIN);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_win"}, win, '0);
        chk({tag, "_win_valid"}, win_valid, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_pix_ready"}, pix_ready, 1'b1);
`ifdef LINE_WINDOW_BORDER_EN
        chk({tag, "_win_border"}, win_border, 1'b0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_outputs("reset");
        @(posedge clk); #1;

        run_frame(0, 0);             // basic frame
        run_frame(0, 0);             // second frame repeats the first

        rdy_mode = 2; stall_left = 5;
        run_frame(0, 0);             // five-cycle stall after the first window
        chk("stall_cycles", 72'(stall_seen), 72'd5);
        rdy_mode = 0;

        run_frame(0, 50);            // random input gaps

        rdy_mode = 1;
        for (int k = 0; k < 3; k++) run_frame(1, 30);
        rdy_mode = 0;

        clear_stats();
        for (int i = 0; i < 3*W + 4; i++) send_pix(PW'(16*(i/W) + (i%W)), 0);
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        run_frame(0, 0);
        chk("accepts_to_first_win", 72'(first_push_acc), 72'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
